rca_accumulator_8bit: RTL and testbench



---
 rtl/rca_accumulator_8bit_pkg.sv | 22 ++
 rtl/rca_accumulator_8bit_adder.sv | 26 ++
 rtl/rca_accumulator_8bit.sv | 136 +++++++++++++
 tb/tb_rca_accumulator_8bit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rca_accumulator_8bit_pkg.sv
// Shared definitions for the carry-counting accumulator: state encoding,
// datapath width and the high-word sizing rule.
package rca_accumulator_8bit_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // True when a HI_W-bit carry count can hold the largest possible burst total.
  function automatic bit hi_width_ok(input int n_ops, input int hi_w);
    longint cap;
    longint worst;
    cap   = (longint'(1) << hi_w) * longint'(256);
    worst = longint'(n_ops) * longint'(255);
    return (cap > worst);
  endfunction

endpackage

// File: rtl/rca_accumulator_8bit_adder.sv
// The team's 8-bit ripple-carry adder: Sum/cout = A + B + cin, one full-adder
// cell per bit with the carry rippling from bit 0 upward.
module rca_accumulator_8bit_adder
  import rca_accumulator_8bit_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              cin,
  output logic [DATA_W-1:0] Sum,
  output logic              cout
);

  logic carry_s;

  // Full-adder chain; carry_s walks the bits so no vector feeds back on itself.
  always_comb begin
    carry_s = cin;
    Sum     = '0;
    for (int i = 0; i < DATA_W; i++) begin
      Sum[i]  = A[i] ^ B[i] ^ carry_s;
      carry_s = (A[i] & B[i]) | (carry_s & (A[i] ^ B[i]));
    end
    cout = carry_s;
  end

endmodule

// File: rtl/rca_accumulator_8bit.sv
// Multi-operand accumulator: sums a burst of bytes through the ripple-carry
// adder, counting carry-outs into a high word, and hands the total downstream.
module rca_accumulator_8bit
  import rca_accumulator_8bit_pkg::*;
#(
  parameter int N_OPS = 4,
  parameter int HI_W  = 2,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic [HI_W-1:0]   out_hi,
  output logic [CNT_W-1:0]  out_cnt
);

  if (N_OPS < 1 || N_OPS > 255) begin : g_bad_n_ops
    $error("rca_accumulator_8bit: N_OPS must be in 1..255");
  end
  if (!hi_width_ok(N_OPS, HI_W)) begin : g_bad_hi_w
    $error("rca_accumulator_8bit: HI_W too narrow for N_OPS*255");
  end

  state_t             state_r;
  state_t             state_s;
  logic [DATA_W-1:0]  acc_r;
  logic [HI_W-1:0]    hi_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               in_ready_r;
  logic               out_valid_r;

  logic               accept_s;
  logic [DATA_W-1:0]  a_s;
  logic [HI_W-1:0]    hi_base_s;
  logic [CNT_W-1:0]   cnt_base_s;
  logic [DATA_W-1:0]  sum_s;
  logic               cout_s;
  logic [HI_W-1:0]    hi_next_s;
  logic [CNT_W-1:0]   cnt_next_s;

  // clr masks the handshake combinationally so an operand offered with it is dropped.
  assign in_ready  = in_ready_r & ~clr;
  assign accept_s  = in_valid & in_ready;
  assign out_valid = out_valid_r;
  assign out_sum   = acc_r;
  assign out_hi    = hi_r;
  assign out_cnt   = cnt_r;

  rca_accumulator_8bit_adder u_adder (
    .A    (a_s),
    .B    (in_data),
    .cin  (1'b0),
    .Sum  (sum_s),
    .cout (cout_s)
  );

  assign hi_next_s  = hi_base_s + HI_W'(cout_s);
  assign cnt_next_s = cnt_base_s + CNT_W'(1);

  // Next-state and adder operand selection; IDLE starts a fresh total from zero.
  always_comb begin
    state_s    = state_r;
    a_s        = acc_r;
    hi_base_s  = hi_r;
    cnt_base_s = cnt_r;
    case (state_r)
      ST_IDLE: begin
        a_s        = '0;
        hi_base_s  = '0;
        cnt_base_s = '0;
        if (accept_s) begin
          if (N_OPS == 1 || in_last) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_ACCUM;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (accept_s && (cnt_next_s == CNT_W'(N_OPS) || in_last)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath registers and registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      acc_r       <= '0;
      hi_r        <= '0;
      cnt_r       <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (clr) begin
      state_r     <= ST_IDLE;
      acc_r       <= '0;
      hi_r        <= '0;
      cnt_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s != ST_DONE);
      out_valid_r <= (state_s == ST_DONE);
      if (accept_s) begin
        acc_r <= sum_s;
        hi_r  <= hi_next_s;
        cnt_r <= cnt_next_s;
      end
    end
  end

endmodule

// File: tb/tb_rca_accumulator_8bit.sv
// Directed and randomized bench for rca_accumulator_8bit; expected totals come
// from plain integer sums of the operands sent.
module tb_rca_accumulator_8bit;

  localparam int N_OPS = 4;
  localparam int HI_W  = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clr = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [7:0]      in_data = 8'd0;
  logic            in_last = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [7:0]      out_sum;
  logic [HI_W-1:0] out_hi;
  logic [7:0]      out_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] ops [0:15];

  rca_accumulator_8bit #(.N_OPS(N_OPS), .HI_W(HI_W), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_hi    (out_hi),
    .out_cnt   (out_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one operand after `gap` idle cycles and hold it until accepted.
  task automatic send_op(input logic [7:0] d, input bit last, input int gap);
    int n;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_timeout", (n < 20), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic send_burst(input int n, input bit use_last, input int max_gap);
    for (int i = 0; i < n; i++) begin
      send_op(ops[i], use_last && (i == n - 1), (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
    end
  endtask

  // Expect the result one cycle after the last accept, stall, then hand it off.
  task automatic finish_burst(input int n, input int stall);
    int total;
    total = 0;
    for (int i = 0; i < n; i++) total += int'(ops[i]);
    @(negedge clk);
    check("out_valid_latency", out_valid, 1);
    check("out_sum", out_sum, total % 256);
    check("out_hi", out_hi, total / 256);
    check("out_cnt", out_cnt, n);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_sum", out_sum, total % 256);
      check("stall_hi", out_hi, total / 256);
      check("stall_cnt", out_cnt, n);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("idle_out_valid", out_valid, 0);
    check("idle_in_ready", in_ready, 1);
  endtask

  initial begin
    int n;
    bit use_last;

    // Reset state
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", out_sum, 0);
    check("rst_hi", out_hi, 0);
    check("rst_cnt", out_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);

    ops[0] = 8'd10; ops[1] = 8'd20; ops[2] = 8'd30; ops[3] = 8'd40;
    send_burst(4, 1'b0, 0);
    finish_burst(4, 0);

    ops[0] = 8'd200; ops[1] = 8'd200; ops[2] = 8'd200; ops[3] = 8'd200;
    send_burst(4, 1'b0, 0);
    finish_burst(4, 0);

    ops[0] = 8'hFF; ops[1] = 8'h01;
    send_burst(2, 1'b1, 0);
    finish_burst(2, 0);

    ops[0] = 8'h7F;
    send_burst(1, 1'b1, 0);
    finish_burst(1, 0);

    ops[0] = 8'd3; ops[1] = 8'd4; ops[2] = 8'd5; ops[3] = 8'd6;
    send_burst(4, 1'b0, 0);
    finish_burst(4, 5);

    // Abort after two operands; an operand offered alongside clr is dropped
    send_op(8'd5, 1'b0, 0);
    send_op(8'd6, 1'b0, 0);
    clr = 1'b1; in_valid = 1'b1; in_data = 8'd99;
    @(negedge clk);
    check("clr_in_ready", in_ready, 0);
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("clr_cnt", out_cnt, 0);
    check("clr_sum", out_sum, 0);
    check("clr_valid", out_valid, 0);
    ops[0] = 8'd1; ops[1] = 8'd1; ops[2] = 8'd1; ops[3] = 8'd1;
    send_burst(4, 1'b0, 0);
    finish_burst(4, 0);

    // clr wins over a DONE handshake
    ops[0] = 8'd10; ops[1] = 8'd20; ops[2] = 8'd30; ops[3] = 8'd40;
    send_burst(4, 1'b0, 0);
    clr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("clr_done_valid", out_valid, 0);
    check("clr_done_cnt", out_cnt, 0);
    check("clr_done_in_ready", in_ready, 1);

    // Asynchronous reset mid-ACCUM, then mid-DONE
    send_op(8'd7, 1'b0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_accum_in_ready", in_ready, 0);
    check("arst_accum_valid", out_valid, 0);
    check("arst_accum_cnt", out_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    ops[0] = 8'd9;
    send_burst(1, 1'b1, 0);
    #2;
    check("pre_arst_done_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("arst_done_valid", out_valid, 0);
    check("arst_done_sum", out_sum, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    ops[0] = 8'd1; ops[1] = 8'd2; ops[2] = 8'd3; ops[3] = 8'd4;
    send_burst(4, 1'b0, 0);
    finish_burst(4, 0);

    // Randomized bursts with gaps, early termination and backpressure
    for (int b = 0; b < 40; b++) begin
      n = $urandom_range(1, N_OPS);
      use_last = (n < N_OPS) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        ops[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      end
      send_burst(n, use_last, 2);
      finish_burst(n, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
